hamming_index_engine: RTL and testbench

//  Consumer stage behind the sync_fifo input buffer. Pops one WIDTH-bit word at a time,

---
 rtl/hamming_index_engine.sv | 123 ++++++++++++
 tb/tb_hamming_index_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_index_engine.sv
// hamming_index_engine: pops one word from the input FIFO, streams the index of
// every set bit (LSB first) over valid/ready, then pulses the word's weight.
module hamming_index_engine #(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int WT_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_emp,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [IDX_W-1:0] idx,
    output logic             idx_last,
    output logic             wt_valid,
    output logic [WT_W-1:0]  wt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] work;
    logic [WT_W-1:0]  rem;
    logic [WT_W-1:0]  data_wt;
    logic [IDX_W-1:0] low_idx;

    // Population count of the word arriving from the FIFO.
    always_comb begin
        data_wt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            data_wt = data_wt + WT_W'(fifo_data[i]);
        end
    end

    // Priority encoder: scanning MSB down leaves the lowest set bit's index.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (work[i-1]) begin
                low_idx = IDX_W'(i - 1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word capture, weight result and per-beat clearing of the lowest set bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work <= '0;
            rem  <= '0;
            wt   <= '0;
        end else begin
            case (state)
                WAIT: begin
                    work <= fifo_data;
                    rem  <= data_wt;
                    wt   <= data_wt;
                end
                SCAN: begin
                    if (idx_ready) begin
                        work <= work & (work - WIDTH'(1));
                        rem  <= rem - WT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and outputs; idx_ready only steers the transition, never the outputs.
    always_comb begin
        state_nxt = state;
        fifo_rd   = 1'b0;
        idx_valid = 1'b0;
        idx       = '0;
        idx_last  = 1'b0;
        wt_valid  = 1'b0;
        case (state)
            IDLE: begin
                fifo_rd = !fifo_emp;
                if (!fifo_emp) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = (|fifo_data) ? SCAN : DONE;
            end
            SCAN: begin
                idx_valid = 1'b1;
                idx       = low_idx;
                idx_last  = (rem == WT_W'(1));
                if (idx_ready && idx_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                wt_valid  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hamming_index_engine.sv
// tb_hamming_index_engine: directed tests with a small behavioural FIFO in front.
module tb_hamming_index_engine;

    logic        clk;
    logic        rst;
    logic        fifo_emp;
    logic        fifo_rd;
    logic [31:0] fifo_data;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  idx;
    logic        idx_last;
    logic        wt_valid;
    logic [5:0]  wt;
    logic        busy;

    int tests;
    int fails;

    logic [31:0] mem [0:63];
    int          wr_ptr;
    int          rd_ptr;

    hamming_index_engine #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_emp  (fifo_emp),
        .fifo_rd   (fifo_rd),
        .fifo_data (fifo_data),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx       (idx),
        .idx_last  (idx_last),
        .wt_valid  (wt_valid),
        .wt        (wt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: data appears the cycle after fifo_rd, zero otherwise.
    assign fifo_emp = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            fifo_data <= '0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({fifo_rd, idx_valid, idx, idx_last, wt_valid, wt, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rd=%b iv=%b idx=%0d last=%b wv=%b wt=%0d busy=%b, need all 0",
                     fifo_rd, idx_valid, idx, idx_last, wt_valid, wt, busy);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || fifo_rd !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_empty: busy=%b rd=%b, need 0 0", busy, fifo_rd);
        end
    endtask

    task automatic test_basic();
        logic [4:0] exp_idx [3];
        exp_idx = '{5'd0, 5'd4, 5'd31};
        idx_ready = 1'b1;
        push(32'h8000_0011);
        tests++;
        if (fifo_rd !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_rd: rd=%b busy=%b, need 1 0", fifo_rd, busy);
        end
        tick();
        tests++;
        if (fifo_rd !== 1'b0 || busy !== 1'b1 || idx_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_wait: rd=%b busy=%b iv=%b, need 0 1 0", fifo_rd, busy, idx_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (idx_valid !== 1'b1 || idx !== exp_idx[k] || idx_last !== (k == 2)) begin
                fails++;
                $display("FAIL basic_idx%0d: iv=%b idx=%0d last=%b, need 1 %0d %b",
                         k, idx_valid, idx, idx_last, exp_idx[k], (k == 2));
            end
        end
        tick();
        tests++;
        if (wt_valid !== 1'b1 || wt !== 6'd3 || idx_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_wt: wv=%b wt=%0d iv=%b, need 1 3 0", wt_valid, wt, idx_valid);
        end
        tick();
        tests++;
        if (wt_valid !== 1'b0 || busy !== 1'b0 || wt !== 6'd3) begin
            fails++;
            $display("FAIL basic_hold: wv=%b busy=%b wt=%0d, need 0 0 3", wt_valid, busy, wt);
        end
    endtask

    task automatic test_zero();
        idx_ready = 1'b1;
        push(32'h0000_0000);
        tests++;
        if (fifo_rd !== 1'b1) begin
            fails++;
            $display("FAIL zero_rd: rd=%b, need 1", fifo_rd);
        end
        tick();
        tests++;
        if (idx_valid !== 1'b0 || wt_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_wait: iv=%b wv=%b, need 0 0", idx_valid, wt_valid);
        end
        tick();
        tests++;
        if (wt_valid !== 1'b1 || wt !== 6'd0 || idx_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_wt: wv=%b wt=%0d iv=%b, need 1 0 0", wt_valid, wt, idx_valid);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || wt_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle: busy=%b wv=%b, need 0 0", busy, wt_valid);
        end
    endtask

    task automatic test_all_ones();
        idx_ready = 1'b1;
        push(32'hFFFF_FFFF);
        tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            tests++;
            if (idx_valid !== 1'b1 || idx !== 5'(i) || idx_last !== (i == 31)) begin
                fails++;
                $display("FAIL ones_idx%0d: iv=%b idx=%0d last=%b, need 1 %0d %b",
                         i, idx_valid, idx, idx_last, i, (i == 31));
            end
        end
        tick();
        tests++;
        if (wt_valid !== 1'b1 || wt !== 6'd32) begin
            fails++;
            $display("FAIL ones_wt: wv=%b wt=%0d, need 1 32", wt_valid, wt);
        end
        tick();
    endtask

    task automatic test_backpressure();
        idx_ready = 1'b0;
        push(32'h0000_0104);
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (idx_valid !== 1'b1 || idx !== 5'd2 || idx_last !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: iv=%b idx=%0d last=%b, need 1 2 0",
                         c, idx_valid, idx, idx_last);
            end
        end
        idx_ready = 1'b1;
        tick();
        tests++;
        if (idx_valid !== 1'b1 || idx !== 5'd8 || idx_last !== 1'b1) begin
            fails++;
            $display("FAIL bp_second: iv=%b idx=%0d last=%b, need 1 8 1", idx_valid, idx, idx_last);
        end
        tick();
        tests++;
        if (wt_valid !== 1'b1 || wt !== 6'd2) begin
            fails++;
            $display("FAIL bp_wt: wv=%b wt=%0d, need 1 2", wt_valid, wt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int rd_count;
        int rd_cyc [2];
        int wt_cyc;
        bit idle_bad;
        idx_ready = 1'b1;
        idle_bad  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (fifo_rd !== 1'b0 || busy !== 1'b0) idle_bad = 1'b1;
        end
        tests++;
        if (idle_bad) begin
            fails++;
            $display("FAIL empty_idle: saw rd or busy while empty, need neither");
        end
        push(32'h0000_0003);
        push(32'h0000_0005);
        rd_count = 0;
        rd_cyc   = '{-1, -1};
        wt_cyc   = -1;
        for (int c = 0; c < 30; c++) begin
            if (fifo_rd === 1'b1) begin
                if (rd_count < 2) rd_cyc[rd_count] = c;
                rd_count++;
            end
            if (wt_valid === 1'b1 && wt_cyc < 0) wt_cyc = c;
            tick();
        end
        tests++;
        if (rd_count !== 2) begin
            fails++;
            $display("FAIL b2b_rd_count: got %0d reads, need 2", rd_count);
        end
        tests++;
        if (rd_cyc[0] !== 0 || wt_cyc !== 4 || rd_cyc[1] !== 5) begin
            fails++;
            $display("FAIL b2b_timing: rd0=%0d wt0=%0d rd1=%0d, need 0 4 5", rd_cyc[0], wt_cyc, rd_cyc[1]);
        end
        tests++;
        if (wt !== 6'd2 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_final: wt=%0d busy=%b, need 2 0", wt, busy);
        end
    endtask

    task automatic test_mid_reset();
        idx_ready = 1'b1;
        push(32'hF000_000F);
        tick();
        tick();
        tick();
        tests++;
        if (idx_valid !== 1'b1 || idx !== 5'd1) begin
            fails++;
            $display("FAIL mr_pre: iv=%b idx=%0d, need 1 1", idx_valid, idx);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({fifo_rd, idx_valid, idx, idx_last, wt_valid, wt, busy} !== '0) begin
            fails++;
            $display("FAIL mr_clear: rd=%b iv=%b idx=%0d last=%b wv=%b wt=%0d busy=%b, need all 0",
                     fifo_rd, idx_valid, idx, idx_last, wt_valid, wt, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (busy !== 1'b0 || idx_valid !== 1'b0) begin
            fails++;
            $display("FAIL mr_idle: busy=%b iv=%b, need 0 0", busy, idx_valid);
        end
        push(32'h0000_0001);
        tick();
        tick();
        tests++;
        if (idx_valid !== 1'b1 || idx !== 5'd0 || idx_last !== 1'b1) begin
            fails++;
            $display("FAIL mr_idx: iv=%b idx=%0d last=%b, need 1 0 1", idx_valid, idx, idx_last);
        end
        tick();
        tests++;
        if (wt_valid !== 1'b1 || wt !== 6'd1) begin
            fails++;
            $display("FAIL mr_wt: wv=%b wt=%0d, need 1 1", wt_valid, wt);
        end
        tick();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        wr_ptr    = 0;
        rd_ptr    = 0;
        fifo_data = '0;
        idx_ready = 1'b1;
        rst       = 1'b1;
        test_reset();
        test_basic();
        test_zero();
        test_all_ones();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
